// File: rtl/e203_exu_nice_csr_shadow.sv
// e203_exu_nice_csr_shadow
//   Shadow copy of the NICE coprocessor CSRs (0xE00..0xE00+NCSR-1).
//   CSR reads return data combinationally from the shadow. Accepted writes
//   update the shadow and are queued in a small FIFO that drains to the
//   coprocessor. The coprocessor can push status updates into the shadow.
//
// Ports:
//   clk, rst_n              core clock, async active-low reset
//   nice_csr_*              request channel from the CSR control stage
//                           (valid/ready/addr/wr/wdata, rdata and oor are combinational)
//   cop_wr_*                queued write channel to the coprocessor (valid/ready/idx/data)
//   cop_upd_*               coprocessor status updates (always accepted)
//   wq_idle                 write queue empty
module e203_exu_nice_csr_shadow #(
    parameter int NCSR       = 8,
    parameter int IDXW       = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            nice_csr_valid,
    output logic            nice_csr_ready,
    input  logic [31:0]     nice_csr_addr,
    input  logic            nice_csr_wr,
    input  logic [31:0]     nice_csr_wdata,
    output logic [31:0]     nice_csr_rdata,
    output logic            nice_csr_oor,
    output logic            cop_wr_valid,
    input  logic            cop_wr_ready,
    output logic [IDXW-1:0] cop_wr_idx,
    output logic [31:0]     cop_wr_data,
    input  logic            cop_upd_valid,
    input  logic [IDXW-1:0] cop_upd_idx,
    input  logic [31:0]     cop_upd_data,
    output logic            wq_idle
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [NCSR-1:0][31:0]       shadow;
    logic [FIFO_DEPTH-1:0][IDXW-1:0] q_idx;
    logic [FIFO_DEPTH-1:0][31:0] q_data;
    logic [PW-1:0]               head, tail;
    logic [CW-1:0]               count;

    logic [7:0]      idx8;
    logic [IDXW-1:0] idx;
    logic            in_range;
    logic            full;
    logic            acc_wr;
    logic            pop;

    // Address bits above [7:0] are never decoded; [11:8] is guaranteed 0xE upstream.
    logic unused_addr;
    assign unused_addr = ^{nice_csr_addr[31:8], idx8[7:IDXW]};

    assign idx8     = nice_csr_addr[7:0];
    assign idx      = idx8[IDXW-1:0];
    assign in_range = (idx8 < 8'(NCSR));

    // Ready is purely a function of FIFO occupancy; reads stall too when full.
    assign full           = (count == CW'(FIFO_DEPTH));
    assign nice_csr_ready = ~full;
    assign nice_csr_oor   = nice_csr_valid & ~in_range;
    assign nice_csr_rdata = in_range ? shadow[idx] : 32'h0;

    assign acc_wr = nice_csr_valid & nice_csr_ready & nice_csr_wr & in_range;

    assign cop_wr_valid = (count != '0);
    assign cop_wr_idx   = q_idx[head];
    assign cop_wr_data  = q_data[head];
    assign wq_idle      = (count == '0);
    assign pop          = cop_wr_valid & cop_wr_ready;

    // CPU write has priority over a same-index status update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else begin
            for (int i = 0; i < NCSR; i++) begin
                if (acc_wr && idx == IDXW'(i))
                    shadow[i] <= nice_csr_wdata;
                else if (cop_upd_valid && cop_upd_idx == IDXW'(i))
                    shadow[i] <= cop_upd_data;
            end
        end
    end

    // Write queue; pointers wrap naturally since FIFO_DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_idx  <= '0;
            q_data <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else begin
            if (acc_wr) begin
                q_idx[tail]  <= idx;
                q_data[tail] <= nice_csr_wdata;
                tail         <= tail + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            case ({acc_wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_e203_exu_nice_csr_shadow.sv
module tb_e203_exu_nice_csr_shadow;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        nice_csr_valid = 0;
    logic        nice_csr_ready;
    logic [31:0] nice_csr_addr = 0;
    logic        nice_csr_wr = 0;
    logic [31:0] nice_csr_wdata = 0;
    logic [31:0] nice_csr_rdata;
    logic        nice_csr_oor;
    logic        cop_wr_valid;
    logic        cop_wr_ready = 0;
    logic [2:0]  cop_wr_idx;
    logic [31:0] cop_wr_data;
    logic        cop_upd_valid = 0;
    logic [2:0]  cop_upd_idx = 0;
    logic [31:0] cop_upd_data = 0;
    logic        wq_idle;

    int tests = 0;
    int fails = 0;

    e203_exu_nice_csr_shadow #(.NCSR(8), .IDXW(3), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .nice_csr_valid(nice_csr_valid), .nice_csr_ready(nice_csr_ready),
        .nice_csr_addr(nice_csr_addr), .nice_csr_wr(nice_csr_wr),
        .nice_csr_wdata(nice_csr_wdata), .nice_csr_rdata(nice_csr_rdata),
        .nice_csr_oor(nice_csr_oor),
        .cop_wr_valid(cop_wr_valid), .cop_wr_ready(cop_wr_ready),
        .cop_wr_idx(cop_wr_idx), .cop_wr_data(cop_wr_data),
        .cop_upd_valid(cop_upd_valid), .cop_upd_idx(cop_upd_idx),
        .cop_upd_data(cop_upd_data), .wq_idle(wq_idle)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        nice_csr_valid = v;
        nice_csr_wr    = wr;
        nice_csr_addr  = addr;
        nice_csr_wdata = wd;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        rst_n = 1;
        step();
        req(1, 0, 32'hE03, 0);
        #1;
        tests++; if (nice_csr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b exp 1", nice_csr_ready); end
        tests++; if (nice_csr_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", nice_csr_rdata); end
        tests++; if (nice_csr_oor !== 1'b0) begin fails++; $display("FAIL reset_oor got %0b exp 0", nice_csr_oor); end
        tests++; if (wq_idle !== 1'b1) begin fails++; $display("FAIL reset_idle got %0b exp 1", wq_idle); end
        tests++; if ({cop_wr_valid, cop_wr_idx, cop_wr_data} !== 36'h0) begin fails++; $display("FAIL reset_cop got v=%0b i=%0d d=%h exp 0", cop_wr_valid, cop_wr_idx, cop_wr_data); end
        req(0, 0, 0, 0);
    endtask

    task automatic test_write();
        cop_wr_ready = 0;
        req(1, 1, 32'hE02, 32'hDEADBEEF);
        step();
        req(1, 0, 32'hE02, 0);
        #1;
        tests++; if (nice_csr_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_rdata got %h exp deadbeef", nice_csr_rdata); end
        tests++; if (cop_wr_valid !== 1'b1) begin fails++; $display("FAIL wr_cop_valid got %0b exp 1", cop_wr_valid); end
        tests++; if (cop_wr_idx !== 3'd2) begin fails++; $display("FAIL wr_cop_idx got %0d exp 2", cop_wr_idx); end
        tests++; if (cop_wr_data !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_cop_data got %h exp deadbeef", cop_wr_data); end
        tests++; if (wq_idle !== 1'b0) begin fails++; $display("FAIL wr_idle got %0b exp 0", wq_idle); end
        req(0, 0, 0, 0);
        cop_wr_ready = 1;
        step();
        cop_wr_ready = 0;
        tests++; if (wq_idle !== 1'b1) begin fails++; $display("FAIL wr_drain_idle got %0b exp 1", wq_idle); end
    endtask

    task automatic test_back_to_back();
        req(1, 1, 32'hE00, 32'd1);
        step();
        req(1, 1, 32'hE01, 32'd2);
        step();
        req(1, 1, 32'hE02, 32'd3);
        #1;
        tests++; if (nice_csr_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %0b exp 0", nice_csr_ready); end
        step();
        tests++; if (nice_csr_ready !== 1'b0) begin fails++; $display("FAIL full_hold_ready got %0b exp 0", nice_csr_ready); end
        tests++; if (cop_wr_idx !== 3'd0 || cop_wr_data !== 32'd1) begin fails++; $display("FAIL full_head0 got i=%0d d=%h exp i=0 d=1", cop_wr_idx, cop_wr_data); end
        cop_wr_ready = 1;
        #1;
        tests++; if (nice_csr_ready !== 1'b0) begin fails++; $display("FAIL no_bypass_ready got %0b exp 0", nice_csr_ready); end
        step();
        cop_wr_ready = 0;
        #1;
        tests++; if (nice_csr_ready !== 1'b1) begin fails++; $display("FAIL after_pop_ready got %0b exp 1", nice_csr_ready); end
        tests++; if (cop_wr_idx !== 3'd1 || cop_wr_data !== 32'd2) begin fails++; $display("FAIL head1 got i=%0d d=%h exp i=1 d=2", cop_wr_idx, cop_wr_data); end
        step();
        req(1, 0, 32'hE02, 0);
        #1;
        tests++; if (nice_csr_ready !== 1'b0) begin fails++; $display("FAIL third_acc_ready got %0b exp 0", nice_csr_ready); end
        tests++; if (nice_csr_rdata !== 32'd3) begin fails++; $display("FAIL third_shadow got %h exp 3", nice_csr_rdata); end
        req(0, 0, 0, 0);
        cop_wr_ready = 1;
        #1;
        tests++; if (cop_wr_idx !== 3'd1 || cop_wr_data !== 32'd2) begin fails++; $display("FAIL drain1 got i=%0d d=%h exp i=1 d=2", cop_wr_idx, cop_wr_data); end
        step();
        tests++; if (cop_wr_idx !== 3'd2 || cop_wr_data !== 32'd3 || cop_wr_valid !== 1'b1) begin fails++; $display("FAIL drain2 got v=%0b i=%0d d=%h exp v=1 i=2 d=3", cop_wr_valid, cop_wr_idx, cop_wr_data); end
        step();
        cop_wr_ready = 0;
        tests++; if (wq_idle !== 1'b1) begin fails++; $display("FAIL drain_idle got %0b exp 1", wq_idle); end
    endtask

    task automatic test_collision();
        req(1, 1, 32'hE05, 32'hAAAA);
        cop_upd_valid = 1; cop_upd_idx = 3'd5; cop_upd_data = 32'h5555;
        step();
        cop_upd_valid = 0;
        req(1, 0, 32'hE05, 0);
        #1;
        tests++; if (nice_csr_rdata !== 32'hAAAA) begin fails++; $display("FAIL coll_same got %h exp aaaa", nice_csr_rdata); end
        tests++; if (cop_wr_idx !== 3'd5 || cop_wr_data !== 32'hAAAA) begin fails++; $display("FAIL coll_fifo got i=%0d d=%h exp i=5 d=aaaa", cop_wr_idx, cop_wr_data); end
        req(0, 0, 0, 0);
        cop_wr_ready = 1;
        step();
        cop_wr_ready = 0;
        tests++; if (wq_idle !== 1'b1) begin fails++; $display("FAIL coll_one_entry got idle=%0b exp 1", wq_idle); end
        req(1, 1, 32'hE05, 32'hBBBB);
        cop_upd_valid = 1; cop_upd_idx = 3'd4; cop_upd_data = 32'h5555;
        step();
        cop_upd_valid = 0;
        req(1, 0, 32'hE04, 0);
        #1;
        tests++; if (nice_csr_rdata !== 32'h5555) begin fails++; $display("FAIL coll_diff4 got %h exp 5555", nice_csr_rdata); end
        req(1, 0, 32'hE05, 0);
        #1;
        tests++; if (nice_csr_rdata !== 32'hBBBB) begin fails++; $display("FAIL coll_diff5 got %h exp bbbb", nice_csr_rdata); end
        req(0, 0, 0, 0);
        cop_wr_ready = 1;
        step();
        cop_wr_ready = 0;
    endtask

    task automatic test_oor();
        req(1, 1, 32'hE09, 32'h1234);
        #1;
        tests++; if (nice_csr_oor !== 1'b1) begin fails++; $display("FAIL oor_flag got %0b exp 1", nice_csr_oor); end
        tests++; if (nice_csr_ready !== 1'b1) begin fails++; $display("FAIL oor_ready got %0b exp 1", nice_csr_ready); end
        step();
        tests++; if (wq_idle !== 1'b1) begin fails++; $display("FAIL oor_nopush got idle=%0b exp 1", wq_idle); end
        req(1, 0, 32'hE09, 0);
        #1;
        tests++; if (nice_csr_rdata !== 32'h0) begin fails++; $display("FAIL oor_rdata got %h exp 0", nice_csr_rdata); end
        req(1, 0, 32'hE01, 0);
        #1;
        tests++; if (nice_csr_rdata !== 32'd2 || nice_csr_oor !== 1'b0) begin fails++; $display("FAIL oor_alias got %h oor=%0b exp 2 oor=0", nice_csr_rdata, nice_csr_oor); end
        req(0, 0, 32'hE09, 0);
        #1;
        tests++; if (nice_csr_oor !== 1'b0) begin fails++; $display("FAIL oor_novalid got %0b exp 0", nice_csr_oor); end
    endtask

    task automatic test_upd_only();
        cop_upd_valid = 1; cop_upd_idx = 3'd3; cop_upd_data = 32'h77;
        step();
        cop_upd_valid = 0;
        req(1, 0, 32'hE03, 0);
        #1;
        tests++; if (nice_csr_rdata !== 32'h77) begin fails++; $display("FAIL upd_rdata got %h exp 77", nice_csr_rdata); end
        tests++; if (wq_idle !== 1'b1) begin fails++; $display("FAIL upd_nopush got idle=%0b exp 1", wq_idle); end
        req(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        req(1, 1, 32'hE00, 32'h11);
        step();
        req(1, 1, 32'hE01, 32'h22);
        step();
        req(0, 0, 0, 0);
        tests++; if (cop_wr_valid !== 1'b1) begin fails++; $display("FAIL pre_rst_valid got %0b exp 1", cop_wr_valid); end
        #2;
        rst_n = 0;
        #1;
        tests++; if (cop_wr_valid !== 1'b0 || wq_idle !== 1'b1) begin fails++; $display("FAIL rst_mid got v=%0b idle=%0b exp v=0 idle=1", cop_wr_valid, wq_idle); end
        tests++; if (cop_wr_idx !== 3'd0 || cop_wr_data !== 32'h0) begin fails++; $display("FAIL rst_mid_head got i=%0d d=%h exp 0", cop_wr_idx, cop_wr_data); end
        #3;
        rst_n = 1;
        step();
        for (int i = 0; i < 8; i++) begin
            req(1, 0, 32'hE00 + 32'(i), 0);
            #1;
            tests++; if (nice_csr_rdata !== 32'h0) begin fails++; $display("FAIL rst_shadow%0d got %h exp 0", i, nice_csr_rdata); end
        end
        req(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_collision();
        test_oor();
        test_upd_only();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
